// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Good bytes land in a 1-entry holding register with ack and overrun reporting.
module ps2_rx #(
    parameter int TIMEOUT = 31999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_ena,
    input  logic       ps2_dat_sync,
    input  logic       rx_inhibit,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ovr,
    output logic       rx_err,
    output logic [1:0] rx_err_code,
    output logic       rx_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TRELOAD = TW'(TIMEOUT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] PRTY = 2'd2;
    localparam logic [1:0] STOP = 2'd3;

    localparam logic [1:0] ERR_PAR  = 2'b01;
    localparam logic [1:0] ERR_FRM  = 2'b10;
    localparam logic [1:0] ERR_TOUT = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          par_q, par_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          good;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q;
        par_d    = par_q;
        err_d    = 1'b0;
        code_d   = code_q;
        good     = 1'b0;

        if (rx_inhibit) begin
            state_d = IDLE;
        end else if (ps2_clk_ena) begin
            case (state_q)
                IDLE: begin
                    if (!ps2_dat_sync) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                        timer_d  = TRELOAD;
                    end
                end
                DATA: begin
                    shift_d  = {ps2_dat_sync, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    timer_d  = TRELOAD;
                    if (bitcnt_q == 3'd7) state_d = PRTY;
                end
                PRTY: begin
                    par_d   = ps2_dat_sync;
                    timer_d = TRELOAD;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!ps2_dat_sync) begin
                        err_d  = 1'b1;
                        code_d = ERR_FRM;
                    end else if ((^shift_q ^ par_q) == 1'b0) begin
                        err_d  = 1'b1;
                        code_d = ERR_PAR;
                    end else begin
                        good = 1'b1;
                    end
                end
            endcase
        end else if (state_q != IDLE) begin
            // An edge arriving with timer==0 is handled above and wins.
            if (timer_q == '0) begin
                state_d = IDLE;
                err_d   = 1'b1;
                code_d  = ERR_TOUT;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (good) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            timer_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            timer_q  <= timer_d;
            par_q    <= par_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_ovr      = ovr_q;
    assign rx_err      = err_q;
    assign rx_err_code = code_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, parity/framing/timeout errors,
// overrun with ack, inhibit abort and mid-frame reset.
module tb_ps2_rx;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       dat;
    logic       inh;
    logic       ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ovr;
    logic       rx_err;
    logic [1:0] rx_err_code;
    logic       rx_busy;

    int tests;
    int fails;

    ps2_rx #(.TIMEOUT(31999)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk_ena  (ena),
        .ps2_dat_sync (dat),
        .rx_inhibit   (inh),
        .rx_ack       (ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ovr       (rx_ovr),
        .rx_err       (rx_err),
        .rx_err_code  (rx_err_code),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the sampling posedge.
    task automatic send_bit(input logic b);
        dat = b;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        dat = 1'b1;
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        gap();
        for (int i = 0; i < nbits; i++) begin
            send_bit(b[i]);
            gap();
        end
    endtask

    // Remaining data bits from index 'from', then parity and stop.
    task automatic send_tail(input logic [7:0] b, input int from,
                             input logic p, input logic stp,
                             input logic ack_stop);
        for (int i = from; i < 8; i++) begin
            send_bit(b[i]);
            gap();
        end
        send_bit(p);
        gap();
        ack = ack_stop;
        send_bit(stp);
        ack = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({rx_data, rx_valid, rx_ovr, rx_err, rx_err_code, rx_busy} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=0",
                {rx_data, rx_valid, rx_ovr, rx_err, rx_err_code, rx_busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        send_bit(1'b0);
        tests++;
        if (rx_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start got=%b want=1", rx_busy);
        end
        gap();
        for (int i = 0; i < 8; i++) begin
            send_bit(i[0] ? 1'b0 : 1'b0);
            break;
        end
        gap();
        // 0x1C: bit0 already sent as 0
        send_tail(8'h1C, 1, 1'b0, 1'b1, 1'b0);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h1C || rx_err !== 1'b0
            || rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL good_1C got v=%b d=%h e=%b b=%b want v=1 d=1c e=0 b=0",
                rx_valid, rx_data, rx_err, rx_busy);
        end
        do_ack();
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL ack_clears_valid got=%b want=0", rx_valid);
        end
    endtask

    task automatic test_parity_err();
        send_head(8'hAA, 8);
        send_bit(1'b0);
        gap();
        send_bit(1'b1);
        tests++;
        if (rx_err !== 1'b1 || rx_err_code !== 2'b01 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL parity_err got e=%b c=%b v=%b want e=1 c=01 v=0",
                rx_err, rx_err_code, rx_valid);
        end
        @(negedge clk);
        tests++;
        if (rx_err !== 1'b0 || rx_err_code !== 2'b01) begin
            fails++;
            $display("FAIL err_pulse_width got e=%b c=%b want e=0 c=01",
                rx_err, rx_err_code);
        end
    endtask

    task automatic test_framing_err();
        send_head(8'h5A, 0);
        send_tail(8'h5A, 0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (rx_err !== 1'b1 || rx_err_code !== 2'b10 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL framing_err got e=%b c=%b v=%b want e=1 c=10 v=0",
                rx_err, rx_err_code, rx_valid);
        end
        gap();
        send_head(8'hF0, 0);
        send_tail(8'hF0, 0, 1'b1, 1'b1, 1'b0);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hF0 || rx_err !== 1'b0) begin
            fails++;
            $display("FAIL after_framing_F0 got v=%b d=%h e=%b want v=1 d=f0 e=0",
                rx_valid, rx_data, rx_err);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        send_head(8'h12, 0);
        send_tail(8'h12, 0, 1'b1, 1'b1, 1'b0);
        gap();
        send_head(8'h34, 0);
        send_tail(8'h34, 0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (rx_data !== 8'h12 || rx_ovr !== 1'b1 || rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL overrun got d=%h o=%b v=%b want d=12 o=1 v=1",
                rx_data, rx_ovr, rx_valid);
        end
        gap();
        send_head(8'h12, 0);
        send_tail(8'h12, 0, 1'b1, 1'b1, 1'b0);
        gap();
        send_head(8'h34, 0);
        send_tail(8'h34, 0, 1'b0, 1'b1, 1'b1);
        tests++;
        if (rx_data !== 8'h34 || rx_ovr !== 1'b0 || rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL ack_on_stop got d=%h o=%b v=%b want d=34 o=0 v=1",
                rx_data, rx_ovr, rx_valid);
        end
        do_ack();
        do_ack();
        tests++;
        if (rx_valid !== 1'b0 || rx_ovr !== 1'b0 || rx_data !== 8'h34) begin
            fails++;
            $display("FAIL ack_idle got v=%b o=%b d=%h want v=0 o=0 d=34",
                rx_valid, rx_ovr, rx_data);
        end
    endtask

    task automatic test_timeout();
        int n;
        int errs;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            gap();
            send_bit(1'b1);
        end
        n = 0;
        for (int i = 1; i <= 40000; i++) begin
            @(negedge clk);
            if (rx_err === 1'b1) begin
                n = i;
                break;
            end
        end
        tests++;
        if (n !== 32000 || rx_err_code !== 2'b11 || rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout got cyc=%0d c=%b b=%b want cyc=32000 c=11 b=0",
                n, rx_err_code, rx_busy);
        end
        gap();
        // Edge lands exactly on the cycle the timer reads zero.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            gap();
            send_bit(1'b1);
        end
        errs = 0;
        for (int i = 0; i < 31999; i++) begin
            @(negedge clk);
            if (rx_err === 1'b1) errs++;
        end
        send_bit(1'b1);
        gap();
        send_tail(8'hFF, 5, 1'b1, 1'b1, 1'b0);
        tests++;
        if (errs !== 0 || rx_err !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'hFF) begin
            fails++;
            $display("FAIL edge_at_zero got errs=%0d e=%b v=%b d=%h want 0 0 1 ff",
                errs, rx_err, rx_valid, rx_data);
        end
        do_ack();
    endtask

    task automatic test_inhibit();
        int errs;
        send_head(8'h0F, 3);
        inh = 1'b1;
        @(negedge clk);
        tests++;
        if (rx_busy !== 1'b0 || rx_err !== 1'b0) begin
            fails++;
            $display("FAIL inhibit_abort got b=%b e=%b want b=0 e=0", rx_busy, rx_err);
        end
        send_bit(1'b0);
        tests++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL inhibit_ignores_edge got b=%b want 0", rx_busy);
        end
        inh = 1'b0;
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (rx_err === 1'b1 || rx_valid === 1'b1) errs++;
        end
        send_head(8'h76, 0);
        send_tail(8'h76, 0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (errs !== 0 || rx_valid !== 1'b1 || rx_data !== 8'h76 || rx_err !== 1'b0) begin
            fails++;
            $display("FAIL after_inhibit_76 got errs=%0d v=%b d=%h e=%b want 0 1 76 0",
                errs, rx_valid, rx_data, rx_err);
        end
        do_ack();
    endtask

    task automatic test_reset_midframe();
        send_head(8'h55, 2);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got b=%b v=%b want 0 0", rx_busy, rx_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ena   = 1'b0;
        dat   = 1'b1;
        inh   = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_parity_err();
        test_framing_err();
        test_back_to_back();
        test_timeout();
        test_inhibit();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
